// File: rtl/bb_and_reg.sv
// rtl/bb_and_reg.sv - registered bitwise AND with parameterised pipeline latency
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset, clears every stage
//   in1      in   WIDTH  operand A
//   in2      in   WIDTH  operand B
//   out1     out  WIDTH  (in1 & in2) delayed by STAGES rising edges
//   out_any  out  1      OR-reduction of out1 (only with BB_AND_REG_ANY_EN)
//
// Parameters:
//   WIDTH    operand/result width, >= 1
//   STAGES   register stages from input sample to out1, 1..8
//
// Optional feature macro: BB_AND_REG_ANY_EN

module bb_and_reg #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
`ifdef BB_AND_REG_ANY_EN
    output logic             out_any,
`endif
    output logic [WIDTH-1:0] out1
);

    logic [WIDTH-1:0] pipe_d;
    logic [WIDTH-1:0] pipe_q [STAGES];

    assign pipe_d = in1 & in2;

    // Stage 0 samples the AND directly, so with STAGES=1 the result is
    // visible right after the same edge that samples the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= pipe_d;
            for (int k = 1; k < STAGES; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign out1 = pipe_q[STAGES-1];

`ifdef BB_AND_REG_ANY_EN
    // Derived from the last stage register, so it tracks out1 exactly.
    assign out_any = |pipe_q[STAGES-1];
`endif

endmodule

// File: tb/tb_bb_and_reg.sv
// tb/tb_bb_and_reg.sv - directed self-checking bench for bb_and_reg

module tb_bb_and_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, a2, out_a;
    logic [7:0] b1, b2, out_b;
    logic [3:0] c1, c2, out_c;
`ifdef BB_AND_REG_ANY_EN
    logic       any_a, any_b, any_c;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bb_and_reg #(.WIDTH(1), .STAGES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in1(a1), .in2(a2),
`ifdef BB_AND_REG_ANY_EN
        .out_any(any_a),
`endif
        .out1(out_a)
    );

    bb_and_reg #(.WIDTH(8), .STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in1(b1), .in2(b2),
`ifdef BB_AND_REG_ANY_EN
        .out_any(any_b),
`endif
        .out1(out_b)
    );

    bb_and_reg #(.WIDTH(4), .STAGES(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in1(c1), .in2(c2),
`ifdef BB_AND_REG_ANY_EN
        .out_any(any_c),
`endif
        .out1(out_c)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a1 = 1'b1; a2 = 1'b1;
        b1 = 8'h00; b2 = 8'h00;
        c1 = 4'h0; c2 = 4'h0;
        #1;
        check("reset_a_init", {7'd0, out_a}, 8'h00);
        check("reset_b_init", out_b, 8'h00);

        // Reset held across three edges with the AND of the inputs equal to 1.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold_a", {7'd0, out_a}, 8'h00);
        end
        rst_n = 1'b1;
        step();
        check("release_a", {7'd0, out_a}, 8'h01);

        // Truth table, one vector per edge.
        a1 = 1'b0; a2 = 1'b0; step(); check("tt_00", {7'd0, out_a}, 8'h00);
        a1 = 1'b0; a2 = 1'b1; step(); check("tt_01", {7'd0, out_a}, 8'h00);
        a1 = 1'b1; a2 = 1'b0; step(); check("tt_10", {7'd0, out_a}, 8'h00);
        a1 = 1'b1; a2 = 1'b1; step(); check("tt_11", {7'd0, out_a}, 8'h01);

        // Bus and latency through three stages.
        b1 = 8'hF0; b2 = 8'h3C; step(); check("lat_edge1", out_b, 8'h00);
        b1 = 8'hFF; b2 = 8'hAA; step(); check("lat_edge2", out_b, 8'h00);
        b1 = 8'h00; b2 = 8'h00; step(); check("lat_edge3", out_b, 8'h30);
        step(); check("lat_edge4", out_b, 8'hAA);
        step(); check("lat_edge5", out_b, 8'h00);

        // Asynchronous reset pulse between edges while FF is in flight.
        b1 = 8'hFF; b2 = 8'hFF; step();
        b1 = 8'h00; b2 = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("async_clr_b", out_b, 8'h00);
        check("async_clr_a", {7'd0, out_a}, 8'h00);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_stale_ff", out_b, 8'h00);
        end
        check("post_pulse_a", {7'd0, out_a}, 8'h01);

        // Input change while clk is high must not show through the falling edge.
        a1 = 1'b0;
        @(negedge clk);
        #1;
        check("negedge_hold", {7'd0, out_a}, 8'h01);
        step();
        check("next_posedge", {7'd0, out_a}, 8'h00);

        // Four-bit operand patterns.
        c1 = 4'b1010; c2 = 4'b0101; step();
        check("c_disjoint", {4'd0, out_c}, 8'h00);
`ifdef BB_AND_REG_ANY_EN
        check("any_zero", {7'd0, any_c}, 8'h00);
`endif
        c1 = 4'b1010; c2 = 4'b1000; step();
        check("c_overlap", {4'd0, out_c}, 8'h08);
`ifdef BB_AND_REG_ANY_EN
        check("any_one", {7'd0, any_c}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("any_reset", {7'd0, any_c}, 8'h00);
        rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
